// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory block port between the I-cache and D-cache miss paths.
// Optional MEM_ARB_RR_EN: ties in IDLE alternate away from the last completed owner.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  wait_cnt,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;
    logic   owner_d;     // 1: D-cache owns the port, 0: I-cache
    logic   i_req, d_req, any_req;
    logic   tie_to_d, grant_d, waiting;

    assign i_req     = i_read;
    assign d_req     = d_read | d_write;
    assign any_req   = i_req | d_req;
    assign fsm_state = state;

`ifdef MEM_ARB_RR_EN
    logic last_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if (state == S_BUSY && mem_ready) begin
            last_d <= owner_d;
        end
    end
    assign tie_to_d = ~last_d;
`else
    assign tie_to_d = 1'b1;
`endif

    assign grant_d = d_req & (~i_req | tie_to_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (any_req) state_next = S_BUSY;
            S_BUSY:  if (mem_ready) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // A cycle counts as waiting when the other side holds, or is just being granted, the port.
    always_comb begin
        waiting = 1'b0;
        case (state)
            S_IDLE:  waiting = any_req & (grant_d ? i_req : d_req);
            S_BUSY,
            S_DONE:  waiting = owner_d ? i_req : d_req;
            default: waiting = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner_d   <= grant_d;
                        mem_addr  <= grant_d ? d_addr : i_addr;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        // a simultaneous D read+write is served as the write-back only
                        mem_write <= grant_d & d_write;
                        mem_read  <= grant_d ? ~d_write : 1'b1;
                    end
                end
                S_BUSY: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (owner_d) begin
                            d_ready <= 1'b1;
                            if (mem_read) d_rdata <= mem_rdata;
                        end else begin
                            i_ready <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
            if (waiting && (wait_cnt != {CNT_W{1'b1}})) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level schedule model predicts service
// order, ready cycles, returned blocks and the saturating wait counter.
module tb_mem_arbiter;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 16;
  localparam int CNT_MAX = 65535;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [CNT_W-1:0]  wait_cnt;
  logic [1:0]        fsm_state;

  // clock / reset block
  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wait_cnt(wait_cnt), .fsm_state(fsm_state)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DATA_W-1:0] exp_rdata [2];
  int                exp_wait;
  bit                last_d;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int tie_winner();
    return (RR_MODE && last_d) ? 0 : 1;
  endfunction

  task automatic model_reset();
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    exp_wait     = 0;
    last_d       = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_mem_read"},  mem_read,  0);
    check({pfx, "_mem_write"}, mem_write, 0);
    check({pfx, "_mem_addr"},  mem_addr,  0);
    check({pfx, "_mem_wdata"}, mem_wdata, 0);
    check({pfx, "_i_rdata"},   i_rdata,   0);
    check({pfx, "_d_rdata"},   d_rdata,   0);
    check({pfx, "_i_ready"},   i_ready,   0);
    check({pfx, "_d_ready"},   d_ready,   0);
    check({pfx, "_wait_cnt"},  wait_cnt,  0);
    check({pfx, "_state"},     fsm_state, 0);
  endtask

  // One scenario: each enabled side raises its request at its start cycle and holds it
  // until its ready pulse; memory answers after the per-side latency.
  // d_kind: 0 read, 1 write, 2 read+write together.
  task automatic run_txn(input bit en_i, input bit en_d, input int s_i, input int s_d,
                         input int lat_i, input int lat_d, input int d_kind,
                         input logic [ADDR_W-1:0] a_i, input logic [ADDR_W-1:0] a_d,
                         input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd_i,
                         input logic [DATA_W-1:0] rd_d, input bit spur);
    bit en[2];
    bit done[2];
    int s[2], lat[2], exp_rdy[2], obs_rdy[2], n_rdy[2], ord[2];
    int first, second, g1, g2, inc, end_c, n_exp, busy_cnt, strobe_cycles, exp_strobe, viol, cur, k;
    logic [ADDR_W-1:0] side_a[2];
    logic [ADDR_W-1:0] cap_a;
    logic              cap_r, cap_w;
    logic [DATA_W-1:0] cap_wd;
    logic [ADDR_W-1:0] log_a[$];
    logic              log_w[$];
    logic              log_r[$];
    logic [DATA_W-1:0] log_wd[$];
    string nm[2];
    nm[0] = "i"; nm[1] = "d";
    en[0] = en_i;   en[1] = en_d;
    s[0] = s_i;     s[1] = s_d;
    lat[0] = lat_i; lat[1] = lat_d;
    side_a[0] = a_i; side_a[1] = a_d;

    // schedule model
    if (en[0] && en[1]) begin
      if (s[1] < s[0]) first = 1;
      else if (s[0] < s[1]) first = 0;
      else first = tie_winner();
    end else begin
      first = en[1] ? 1 : 0;
    end
    second = 1 - first;
    ord[0] = first; ord[1] = second;
    g1 = s[first];
    exp_rdy[first]  = g1 + lat[first] + 1;
    exp_rdy[second] = -1;
    end_c = exp_rdy[first];
    n_exp = 1;
    inc = 0;
    exp_strobe = lat[first];
    if (en[second]) begin
      g2 = (s[second] > g1 + lat[first] + 2) ? s[second] : g1 + lat[first] + 2;
      exp_rdy[second] = g2 + lat[second] + 1;
      end_c = exp_rdy[second];
      inc = g1 + lat[first] + 2 - ((s[second] > g1) ? s[second] : g1);
      if (inc < 0) inc = 0;
      n_exp = 2;
      exp_strobe += lat[second];
    end
    end_c += 3;

    // driver + memory responder
    i_addr = a_i; d_addr = a_d; d_wdata = wd;
    done[0] = 0; done[1] = 0;
    obs_rdy[0] = -1; obs_rdy[1] = -1; n_rdy[0] = 0; n_rdy[1] = 0;
    busy_cnt = 0; strobe_cycles = 0; viol = 0;
    cap_a = '0; cap_r = 0; cap_w = 0; cap_wd = '0;
    for (int c = 0; c <= end_c; c++) begin
      @(negedge clk);
      if (i_ready) begin n_rdy[0]++; if (obs_rdy[0] < 0) obs_rdy[0] = c; end
      if (d_ready) begin n_rdy[1]++; if (obs_rdy[1] < 0) obs_rdy[1] = c; end
      if (mem_read || mem_write) begin
        if (busy_cnt == 0) begin
          cap_a = mem_addr; cap_r = mem_read; cap_w = mem_write; cap_wd = mem_wdata;
        end else if (mem_addr !== cap_a || mem_read !== cap_r || mem_write !== cap_w || mem_wdata !== cap_wd) begin
          viol++;
        end
        busy_cnt++;
        strobe_cycles++;
        cur = (en[1] && mem_addr == a_d) ? 1 : 0;
        if (busy_cnt == lat[cur]) begin
          mem_ready = 1'b1;
          mem_rdata = cur ? rd_d : rd_i;
          log_a.push_back(cap_a); log_w.push_back(cap_w);
          log_r.push_back(cap_r); log_wd.push_back(cap_wd);
        end else begin
          mem_ready = 1'b0;
          mem_rdata = rand_data();
        end
      end else begin
        busy_cnt  = 0;
        mem_ready = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = rand_data();
      end
      i_read  = en[0] && c >= s[0] && !done[0];
      d_read  = en[1] && c >= s[1] && !done[1] && (d_kind != 1);
      d_write = en[1] && c >= s[1] && !done[1] && (d_kind != 0);
      if (i_ready) done[0] = 1;
      if (d_ready) done[1] = 1;
    end
    @(negedge clk);
    mem_ready = 1'b0;

    // model update
    if (en[0]) exp_rdata[0] = rd_i;
    if (en[1] && d_kind == 0) exp_rdata[1] = rd_d;
    last_d = (ord[n_exp-1] == 1);
    exp_wait = (exp_wait + inc > CNT_MAX) ? CNT_MAX : exp_wait + inc;

    // scoreboard
    for (int j = 0; j < 2; j++) begin
      check({"rdy_cycle_", nm[j]}, obs_rdy[j], exp_rdy[j]);
      check({"rdy_count_", nm[j]}, n_rdy[j], en[j] ? 1 : 0);
    end
    check("mem_txn_count", log_a.size(), n_exp);
    for (int j = 0; j < n_exp; j++) begin
      if (j < log_a.size()) begin
        k = ord[j];
        check($sformatf("txn%0d_addr", j), log_a[j], side_a[k]);
        check($sformatf("txn%0d_write", j), log_w[j], (k == 1 && d_kind != 0) ? 1 : 0);
        check($sformatf("txn%0d_read", j), log_r[j], (k == 1 && d_kind != 0) ? 0 : 1);
        if (k == 1 && d_kind != 0) check($sformatf("txn%0d_wdata", j), log_wd[j], wd);
      end
    end
    check("strobe_cycles", strobe_cycles, exp_strobe);
    check("strobe_stable", viol, 0);
    check("i_rdata", i_rdata, exp_rdata[0]);
    check("d_rdata", d_rdata, exp_rdata[1]);
    check("wait_cnt", wait_cnt, exp_wait);
    check("idle_after", fsm_state, 0);
  endtask

  task automatic reset_mid_txn();
    int n_rdy;
    @(negedge clk);
    d_addr = 28'h0000444; d_wdata = rand_data(); d_write = 1'b1; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy_write", mem_write, 1);
    rst = 1'b1; d_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_outputs("mid_rst");
    n_rdy = 0;
    repeat (5) begin
      @(negedge clk);
      n_rdy += int'(i_ready) + int'(d_ready);
    end
    check("mid_rst_no_ready", n_rdy, 0);
    check("mid_rst_idle", fsm_state, 0);
  endtask

  task automatic spurious_idle();
    int n_ev;
    n_ev = 0;
    repeat (6) begin
      @(negedge clk);
      n_ev += int'(i_ready) + int'(d_ready) + int'(mem_read) + int'(mem_write) + int'(fsm_state != 0);
      mem_ready = 1'b1;
      mem_rdata = rand_data();
    end
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    n_ev += int'(i_ready) + int'(d_ready) + int'(fsm_state != 0);
    check("spur_idle_events", n_ev, 0);
    check("spur_i_rdata", i_rdata, exp_rdata[0]);
    check("spur_d_rdata", d_rdata, exp_rdata[1]);
    check("spur_wait_cnt", wait_cnt, exp_wait);
  endtask

  initial begin
    int ei, ed, si, sd, li, ld, kind, big;
    logic [ADDR_W-1:0] ai, ad;
    rst = 1'b1;
    i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // I read, latency 4, A5 pattern
    run_txn(1, 0, 0, 0, 4, 1, 0, 28'h0000010, 28'h8000000, '0, {16{8'hA5}}, '0, 0);
    // D write-back
    run_txn(0, 1, 0, 0, 1, 3, 1, 28'h0000000, 28'h0000020, {8{16'h1234}}, '0, rand_data(), 0);
    // simultaneous requests, latency 2 each, twice to see the tie resolution after each owner
    run_txn(1, 1, 0, 0, 2, 2, 0, 28'h0000100, 28'h8000200, '0, rand_data(), rand_data(), 0);
    run_txn(1, 1, 0, 0, 2, 2, 0, 28'h0000300, 28'h8000400, '0, rand_data(), rand_data(), 0);
    // read and write raised together on D
    run_txn(0, 1, 0, 0, 1, 2, 2, 28'h0000000, 28'h8000500, rand_data(), '0, rand_data(), 0);

    reset_mid_txn();
    run_txn(1, 0, 1, 0, 1, 1, 0, 28'h0000600, 28'h8000000, '0, rand_data(), '0, 0);
    spurious_idle();
    // spurious mem_ready around a transaction (IDLE and DONE cycles)
    run_txn(1, 1, 0, 2, 3, 1, 0, 28'h0000700, 28'h8000800, '0, rand_data(), rand_data(), 1);

    for (int n = 0; n < 40; n++) begin
      ei = $urandom_range(0, 1);
      ed = (ei == 0) ? 1 : $urandom_range(0, 1);
      si = $urandom_range(0, 3);
      sd = ($urandom_range(0, 2) == 0) ? si : $urandom_range(0, 3);
      li = $urandom_range(1, 5);
      ld = $urandom_range(1, 5);
      kind = $urandom_range(0, 2);
      ai = {1'b0, 27'($urandom)};
      ad = {1'b1, 27'($urandom)};
      run_txn(1'(ei), 1'(ed), si, sd, li, ld, kind, ai, ad, rand_data(), rand_data(), rand_data(),
              1'($urandom_range(0, 1)));
    end

    // keep I waiting behind a long D write so the counter runs past all-ones
    big = CNT_MAX - exp_wait + 5;
    run_txn(1, 1, 1, 0, 1, big, 1, 28'h0000900, 28'h8000A00, rand_data(), rand_data(), '0, 0);
    run_txn(1, 1, 0, 0, 2, 2, 0, 28'h0000B00, 28'h8000C00, '0, rand_data(), rand_data(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
